// File: rtl/roce_mem_write_splitter.sv
// -----------------------------------------------------------------------------
// roce_mem_write_splitter
//
// Splits RoCE memory-write commands (vaddr, length) into DMA write commands
// that never cross a PAGE_BYTES boundary and never exceed MAX_BURST bytes, and
// re-frames the write data stream so that tlast closes every emitted chunk.
// The command side and the data side are decoupled by a small chunk-length
// FIFO; each entry carries the chunk length plus a flag marking the final
// chunk of the message, which the data side uses to check the input tlast.
//
// Ports
//   net_clk, net_aresetn        clock, asynchronous active-low reset
//   s_axis_wr_cmd_*             input command  {len[95:64], vaddr[63:0]}
//   s_axis_wr_data_*            input payload stream (data/keep/last)
//   m_axis_dma_cmd_*            output chunk command {len[95:64], addr[63:0]}
//   m_axis_dma_data_*           output payload, last closes each chunk
//   err_unaligned               1-cycle pulse: accepted vaddr not beat aligned
//   err_last_mismatch           1-cycle pulse: input last disagrees with
//                               the message end
// -----------------------------------------------------------------------------
module roce_mem_write_splitter #(
    parameter int unsigned DATA_BITS      = 512,
    parameter int unsigned PAGE_BYTES     = 4096,
    parameter int unsigned MAX_BURST      = 4096,
    parameter int unsigned LEN_FIFO_DEPTH = 8
) (
    input  logic                   net_clk,
    input  logic                   net_aresetn,
    input  logic                   s_axis_wr_cmd_valid,
    output logic                   s_axis_wr_cmd_ready,
    input  logic [95:0]            s_axis_wr_cmd_data,
    input  logic                   s_axis_wr_data_valid,
    output logic                   s_axis_wr_data_ready,
    input  logic [DATA_BITS-1:0]   s_axis_wr_data_data,
    input  logic [DATA_BITS/8-1:0] s_axis_wr_data_keep,
    input  logic                   s_axis_wr_data_last,
    output logic                   m_axis_dma_cmd_valid,
    input  logic                   m_axis_dma_cmd_ready,
    output logic [95:0]            m_axis_dma_cmd_data,
    output logic                   m_axis_dma_data_valid,
    input  logic                   m_axis_dma_data_ready,
    output logic [DATA_BITS-1:0]   m_axis_dma_data_data,
    output logic [DATA_BITS/8-1:0] m_axis_dma_data_keep,
    output logic                   m_axis_dma_data_last,
    output logic                   err_unaligned,
    output logic                   err_last_mismatch
);

    localparam int unsigned BEAT_BYTES = DATA_BITS / 8;
    localparam int unsigned PTR_W      = (LEN_FIFO_DEPTH > 1) ? $clog2(LEN_FIFO_DEPTH) : 1;
    localparam logic [31:0] BEAT_LEN   = 32'(BEAT_BYTES);
    localparam logic [31:0] PAGE_LEN   = 32'(PAGE_BYTES);
    localparam logic [31:0] BURST_LEN  = 32'(MAX_BURST);
    localparam logic [63:0] ALIGN_MASK = ~(64'(BEAT_BYTES) - 64'd1);
    localparam logic [PTR_W:0]   FIFO_FULL_CNT = (PTR_W+1)'(LEN_FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST      = PTR_W'(LEN_FIFO_DEPTH - 1);

    typedef enum logic [0:0] {C_IDLE = 1'b0, C_ISSUE = 1'b1} cmd_state_e;
    typedef enum logic [0:0] {D_IDLE = 1'b0, D_XFER  = 1'b1} data_state_e;

    // Largest chunk starting at a: limited by the bytes left, the distance
    // to the next page boundary and the burst limit.
    function automatic logic [31:0] chunk_of(input logic [63:0] a, input logic [31:0] r);
        logic [31:0] space;
        logic [31:0] c;
        space = PAGE_LEN - (a[31:0] & (PAGE_LEN - 32'd1));
        c     = (space < r) ? space : r;
        c     = (BURST_LEN < c) ? BURST_LEN : c;
        return c;
    endfunction

    // FIFO pointer increment with explicit wrap so any depth works.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? {PTR_W{1'b0}} : (p + PTR_W'(1));
    endfunction

    // ---------------- command path ----------------
    cmd_state_e  cstate_r, cstate_s;
    logic [63:0] addr_r;
    logic [31:0] rem_r;
    logic [31:0] chunk_r;
    logic        cmd_ready_r;
    logic        err_unaligned_r;

    logic [63:0] in_addr_s, in_addr_aligned_s, addr_nxt_s;
    logic [31:0] in_len_s, rem_nxt_s;
    logic        in_unaligned_s;
    logic        cmd_in_hs_s, cmd_out_valid_s, cmd_out_hs_s, cmd_done_s;

    // FIFO
    logic [32:0]      len_mem_r [LEN_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             fifo_full_s, fifo_empty_s, push_s, pop_s;
    logic [32:0]      head_s;

    // ---------------- data path ----------------
    data_state_e dstate_r, dstate_s;
    logic [31:0] bcnt_r;
    logic        chunk_last_r;
    logic        err_last_r;
    logic        beat_hs_s, chunk_end_beat_s, chunk_end_s;

    assign in_addr_s         = s_axis_wr_cmd_data[63:0];
    assign in_len_s          = s_axis_wr_cmd_data[95:64];
    assign in_addr_aligned_s = in_addr_s & ALIGN_MASK;
    assign in_unaligned_s    = |(in_addr_s & ~ALIGN_MASK);
    assign addr_nxt_s        = addr_r + {32'd0, chunk_r};
    assign rem_nxt_s         = rem_r - chunk_r;

    assign cmd_in_hs_s  = s_axis_wr_cmd_valid & cmd_ready_r;
    assign cmd_out_hs_s = cmd_out_valid_s & m_axis_dma_cmd_ready;
    assign cmd_done_s   = cmd_out_hs_s & (rem_r == chunk_r);

    assign fifo_full_s  = (count_r == FIFO_FULL_CNT);
    assign fifo_empty_s = (count_r == {(PTR_W+1){1'b0}});
    assign push_s       = cmd_out_hs_s;
    assign head_s       = len_mem_r[rd_ptr_r];

    assign s_axis_wr_cmd_ready  = cmd_ready_r;
    assign m_axis_dma_cmd_valid = cmd_out_valid_s;
    assign m_axis_dma_cmd_data  = {chunk_r, addr_r};
    assign err_unaligned        = err_unaligned_r;
    assign err_last_mismatch    = err_last_r;

    // Command FSM state register
    always_ff @(posedge net_clk or negedge net_aresetn) begin
        if (!net_aresetn) begin
            cstate_r <= C_IDLE;
        end else begin
            cstate_r <= cstate_s;
        end
    end

    // Command FSM next-state: a zero-length command is consumed in C_IDLE
    always_comb begin
        cstate_s = cstate_r;
        case (cstate_r)
            C_IDLE: begin
                if (cmd_in_hs_s && (in_len_s != 32'd0)) begin
                    cstate_s = C_ISSUE;
                end else begin
                    cstate_s = C_IDLE;
                end
            end
            C_ISSUE: begin
                if (cmd_done_s) begin
                    cstate_s = C_IDLE;
                end else begin
                    cstate_s = C_ISSUE;
                end
            end
            default: cstate_s = C_IDLE;
        endcase
    end

    // Command FSM output decode: issue only while the length FIFO has room
    always_comb begin
        if (cstate_r == C_ISSUE) begin
            cmd_out_valid_s = ~fifo_full_s;
        end else begin
            cmd_out_valid_s = 1'b0;
        end
    end

    // Registered command-side outputs and the running address/remainder;
    // chunk_r is recomputed whenever addr/rem move so the output is a register
    always_ff @(posedge net_clk or negedge net_aresetn) begin
        if (!net_aresetn) begin
            cmd_ready_r     <= 1'b0;
            err_unaligned_r <= 1'b0;
            addr_r          <= 64'd0;
            rem_r           <= 32'd0;
            chunk_r         <= 32'd0;
        end else begin
            cmd_ready_r     <= (cstate_s == C_IDLE);
            err_unaligned_r <= cmd_in_hs_s & in_unaligned_s;
            if (cmd_in_hs_s) begin
                addr_r  <= in_addr_aligned_s;
                rem_r   <= in_len_s;
                chunk_r <= chunk_of(in_addr_aligned_s, in_len_s);
            end else if (cmd_out_hs_s) begin
                addr_r  <= addr_nxt_s;
                rem_r   <= rem_nxt_s;
                chunk_r <= chunk_of(addr_nxt_s, rem_nxt_s);
            end else begin
                addr_r  <= addr_r;
                rem_r   <= rem_r;
                chunk_r <= chunk_r;
            end
        end
    end

    // Chunk-length FIFO storage: {final-chunk flag, length}
    always_ff @(posedge net_clk) begin
        if (push_s) begin
            len_mem_r[wr_ptr_r] <= {(rem_r == chunk_r), chunk_r};
        end
    end

    // Chunk-length FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge net_clk or negedge net_aresetn) begin
        if (!net_aresetn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            wr_ptr_r <= push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
            rd_ptr_r <= pop_s  ? ptr_inc(rd_ptr_r) : rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign beat_hs_s        = (dstate_r == D_XFER) & s_axis_wr_data_valid & m_axis_dma_data_ready;
    assign chunk_end_beat_s = (bcnt_r <= BEAT_LEN);
    assign chunk_end_s      = beat_hs_s & chunk_end_beat_s;
    // Pop when idle, or on the closing beat so back-to-back chunks need no bubble
    assign pop_s            = ~fifo_empty_s & ((dstate_r == D_IDLE) | chunk_end_s);

    assign m_axis_dma_data_data = s_axis_wr_data_data;
    assign m_axis_dma_data_keep = s_axis_wr_data_keep;

    // Data FSM state register
    always_ff @(posedge net_clk or negedge net_aresetn) begin
        if (!net_aresetn) begin
            dstate_r <= D_IDLE;
        end else begin
            dstate_r <= dstate_s;
        end
    end

    // Data FSM next-state
    always_comb begin
        dstate_s = dstate_r;
        case (dstate_r)
            D_IDLE: begin
                if (pop_s) begin
                    dstate_s = D_XFER;
                end else begin
                    dstate_s = D_IDLE;
                end
            end
            D_XFER: begin
                if (chunk_end_s && fifo_empty_s) begin
                    dstate_s = D_IDLE;
                end else begin
                    dstate_s = D_XFER;
                end
            end
            default: dstate_s = D_IDLE;
        endcase
    end

    // Data FSM output decode: pass-through only while a chunk is open
    always_comb begin
        if (dstate_r == D_XFER) begin
            m_axis_dma_data_valid = s_axis_wr_data_valid;
            s_axis_wr_data_ready  = m_axis_dma_data_ready;
            m_axis_dma_data_last  = chunk_end_beat_s;
        end else begin
            m_axis_dma_data_valid = 1'b0;
            s_axis_wr_data_ready  = 1'b0;
            m_axis_dma_data_last  = 1'b0;
        end
    end

    // Byte counter of the open chunk and last-mismatch detection
    always_ff @(posedge net_clk or negedge net_aresetn) begin
        if (!net_aresetn) begin
            bcnt_r       <= 32'd0;
            chunk_last_r <= 1'b0;
            err_last_r   <= 1'b0;
        end else begin
            // Message ends on the closing beat of the chunk flagged final
            err_last_r <= beat_hs_s & (s_axis_wr_data_last != (chunk_last_r & chunk_end_beat_s));
            if (pop_s) begin
                bcnt_r       <= head_s[31:0];
                chunk_last_r <= head_s[32];
            end else if (beat_hs_s) begin
                bcnt_r       <= chunk_end_beat_s ? 32'd0 : (bcnt_r - BEAT_LEN);
                chunk_last_r <= chunk_last_r;
            end else begin
                bcnt_r       <= bcnt_r;
                chunk_last_r <= chunk_last_r;
            end
        end
    end

endmodule
